// File: rtl/cnt_pwm_gen_pkg.sv
// =============================================================================
// cnt_pwm_gen_pkg : shared types, constants and helpers for counter consumers
// Revision: 1.0
// =============================================================================
`default_nettype none

package cnt_pwm_gen_pkg;

    localparam int CNT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        RUN   = 2'd2
    } pwm_state_t;

    // Limits a requested duty to the full-period value 2^width.
    function automatic int unsigned clamp_duty(input int unsigned duty, input int unsigned width);
        int unsigned max_duty;
        max_duty = 32'd1 << width;
        return (duty > max_duty) ? max_duty : duty;
    endfunction

endpackage

`default_nettype wire

// File: rtl/cnt_wrap_det.sv
// =============================================================================
// cnt_wrap_det : flags a period start when the upstream count steps backwards
// Revision: 1.0
// =============================================================================
`default_nettype none

module cnt_wrap_det
    import cnt_pwm_gen_pkg::*;
#(
    parameter int WIDTH = CNT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] cnt_i,
    output logic             wrap_o
);

    logic [WIDTH-1:0] r_cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt_q <= '0;
        end else begin
            r_cnt_q <= cnt_i;
        end
    end

    // A decrease covers both natural rollover and an upstream counter reset.
    assign wrap_o = (cnt_i < r_cnt_q);

endmodule

`default_nettype wire

// File: rtl/cnt_pwm_gen.sv
// =============================================================================
// cnt_pwm_gen : PWM generator driven by an external up-counter, with
//               wrap-synchronised duty updates and a sticky update interrupt
// Revision: 1.0
// =============================================================================
`default_nettype none

module cnt_pwm_gen
    import cnt_pwm_gen_pkg::*;
#(
    parameter int WIDTH    = CNT_WIDTH,
    parameter int PCNT_W   = 16,
    parameter int DUTY_RST = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [WIDTH-1:0]  cnt_i,
    input  logic              en_i,
    input  logic              cfg_valid_i,
    output logic              cfg_ready_o,
    input  logic [WIDTH:0]    cfg_duty_i,
    output logic              pwm_o,
    output logic [PCNT_W-1:0] per_cnt_o,
    output logic              irq_o,
    input  logic              irq_ack_i
);

    pwm_state_t        r_state;
    logic              r_pending;
    logic [WIDTH:0]    r_duty_pend;
    logic [WIDTH:0]    r_duty_act;
    logic              r_pwm;
    logic [PCNT_W-1:0] r_per_cnt;
    logic              r_irq;

    logic              w_wrap;
    logic              w_xfer;
    logic              w_load;
    logic [WIDTH:0]    w_duty_clamped;
    logic [WIDTH:0]    w_duty_eff;
    logic              w_pwm_cmp;

    cnt_wrap_det #(
        .WIDTH (WIDTH)
    ) u_wrap_det (
        .clk    (clk),
        .reset  (reset),
        .cnt_i  (cnt_i),
        .wrap_o (w_wrap)
    );

    assign cfg_ready_o    = !r_pending;
    assign w_xfer         = cfg_valid_i && !r_pending;
    assign w_load         = (r_state != IDLE) && w_wrap && r_pending;
    assign w_duty_clamped = (WIDTH+1)'(clamp_duty(32'(cfg_duty_i), WIDTH));

    // The period that starts on this wrap already uses the newly loaded duty.
    assign w_duty_eff     = w_load ? r_duty_pend : r_duty_act;
    assign w_pwm_cmp      = ({1'b0, cnt_i} < w_duty_eff);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_pending   <= 1'b0;
            r_duty_pend <= '0;
            r_duty_act  <= (WIDTH+1)'(DUTY_RST);
            r_pwm       <= 1'b0;
            r_per_cnt   <= '0;
            r_irq       <= 1'b0;
        end else begin
            // Transfer needs an empty slot and load needs a full one, so
            // the two never coincide.
            if (w_xfer) begin
                r_duty_pend <= w_duty_clamped;
                r_pending   <= 1'b1;
            end else if (w_load) begin
                r_pending   <= 1'b0;
            end

            if (w_load) begin
                r_duty_act <= r_duty_pend;
                r_irq      <= 1'b1;
            end else if (irq_ack_i) begin
                r_irq      <= 1'b0;
            end

            case (r_state)
                IDLE: begin
                    r_pwm <= 1'b0;
                    if (en_i) begin
                        r_state   <= ARMED;
                        r_per_cnt <= '0;
                    end
                end
                ARMED: begin
                    if (!en_i) begin
                        r_state <= IDLE;
                        r_pwm   <= 1'b0;
                    end else if (w_wrap) begin
                        r_state <= RUN;
                        r_pwm   <= w_pwm_cmp;
                    end else begin
                        r_pwm   <= 1'b0;
                    end
                end
                RUN: begin
                    if (w_wrap && (r_per_cnt != '1)) begin
                        r_per_cnt <= r_per_cnt + PCNT_W'(1);
                    end
                    if (!en_i) begin
                        r_state <= IDLE;
                        r_pwm   <= 1'b0;
                    end else begin
                        r_pwm   <= w_pwm_cmp;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_pwm   <= 1'b0;
                end
            endcase
        end
    end

    assign pwm_o     = r_pwm;
    assign per_cnt_o = r_per_cnt;
    assign irq_o     = r_irq;

endmodule

`default_nettype wire

// File: tb/tb_cnt_pwm_gen.sv
// =============================================================================
// tb_cnt_pwm_gen : directed and randomized checks of cnt_pwm_gen at WIDTH=4
// Revision: 1.0
// =============================================================================
`default_nettype none

module tb_cnt_pwm_gen;

    localparam int WIDTH  = 4;
    localparam int PCNT_W = 16;
    localparam int FULL   = 1 << WIDTH;
    localparam int PMAX   = (1 << PCNT_W) - 1;

    logic              clk;
    logic              reset;
    logic [WIDTH-1:0]  cnt_i;
    logic              en_i;
    logic              cfg_valid_i;
    logic              cfg_ready_o;
    logic [WIDTH:0]    cfg_duty_i;
    logic              pwm_o;
    logic [PCNT_W-1:0] per_cnt_o;
    logic              irq_o;
    logic              irq_ack_i;

    int checks = 0;
    int errors = 0;

    cnt_pwm_gen #(
        .WIDTH    (WIDTH),
        .PCNT_W   (PCNT_W),
        .DUTY_RST (0)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .cnt_i       (cnt_i),
        .en_i        (en_i),
        .cfg_valid_i (cfg_valid_i),
        .cfg_ready_o (cfg_ready_o),
        .cfg_duty_i  (cfg_duty_i),
        .pwm_o       (pwm_o),
        .per_cnt_o   (per_cnt_o),
        .irq_o       (irq_o),
        .irq_ack_i   (irq_ack_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    // m_on: enabled and waiting or running; m_run: at least one period started.
    int unsigned m_prev;
    bit          m_on;
    bit          m_run;
    bit          m_pwm;
    bit          m_irq;
    int          m_per;
    int          m_duty;
    int          pend_q[$];
    bit          m_wrap;
    bit          m_live;
    bit          m_empty;
    int          m_eff;

    always @(posedge clk) begin
        if (reset) begin
            m_prev = 0; m_on = 0; m_run = 0; m_pwm = 0; m_irq = 0;
            m_per = 0; m_duty = 0; pend_q.delete();
        end else begin
            m_wrap  = (int'(cnt_i) < m_prev);
            m_prev  = cnt_i;
            m_empty = (pend_q.size() == 0);
            m_live  = m_on && m_wrap && !m_empty;
            m_eff   = m_duty;
            if (m_live) begin
                m_eff  = pend_q.pop_front();
                m_duty = m_eff;
                m_irq  = 1;
            end else if (irq_ack_i) begin
                m_irq = 0;
            end
            m_pwm = en_i && m_on && (m_run || m_wrap) && (int'(cnt_i) < m_eff);
            if (m_run && m_wrap && m_per < PMAX) m_per++;
            if (!m_on) begin
                if (en_i) begin m_on = 1; m_per = 0; end
            end else if (!en_i) begin
                m_on = 0; m_run = 0;
            end else if (m_wrap) begin
                m_run = 1;
            end
            if (cfg_valid_i && m_empty)
                pend_q.push_back((int'(cfg_duty_i) > FULL) ? FULL : int'(cfg_duty_i));
        end
        #2;
        check("mdl_pwm",   pwm_o,       m_pwm);
        check("mdl_irq",   irq_o,       m_irq);
        check("mdl_per",   per_cnt_o,   m_per);
        check("mdl_ready", cfg_ready_o, pend_q.size() == 0);
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc();
        @(negedge clk);
        cnt_i = cnt_i + 1'b1;
    endtask

    task automatic align();
        int n;
        n = 0;
        while (cnt_i != 0 && n < 40) begin
            cyc();
            n++;
        end
        check("align_timeout", n < 40, 1);
    endtask

    task automatic measure(output int high);
        high = 0;
        for (int i = 0; i < FULL; i++) begin
            cyc();
            if (i == 2) irq_ack_i = 1'b1;
            if (i == 3) irq_ack_i = 1'b0;
            high += int'(pwm_o);
        end
    endtask

    task automatic load_and_measure(input int duty, input int exp, input string name);
        int high;
        cfg_valid_i = 1'b1;
        cfg_duty_i  = (WIDTH+1)'(duty);
        cyc();
        cfg_valid_i = 1'b0;
        align();
        measure(high);
        check(name, high, exp);
    endtask

    int high;
    int bad;
    int per_before;
    bit last_ready;

    initial begin
        reset = 1'b1; en_i = 1'b0; cfg_valid_i = 1'b0; cfg_duty_i = '0;
        irq_ack_i = 1'b0; cnt_i = '0;
        repeat (2) @(negedge clk);
        check("rst_pwm",   pwm_o,       0);
        check("rst_irq",   irq_o,       0);
        check("rst_per",   per_cnt_o,   0);
        check("rst_ready", cfg_ready_o, 1);
        reset = 1'b0;

        // Disabled: nothing moves while the counter runs a full period.
        bad = 0;
        repeat (16) begin
            cyc();
            if (pwm_o || irq_o || per_cnt_o != 0 || !cfg_ready_o) bad++;
        end
        check("idle_quiet", bad, 0);

        // Duty 5 accepted in IDLE, then enable.
        repeat (3) cyc();
        cfg_valid_i = 1'b1; cfg_duty_i = 5'd5;
        cyc();
        cfg_valid_i = 1'b0;
        check("pend_ready_low", cfg_ready_o, 0);
        en_i = 1'b1;
        high = 0;
        bad = 0;
        while (cnt_i != 0 && bad < 40) begin
            cyc();
            high += int'(pwm_o);
            bad++;
        end
        check("armed_no_pwm", high, 0);
        for (int p = 0; p < 4; p++) begin
            high = 0;
            for (int i = 0; i < FULL; i++) begin
                cyc();
                if (i == 0) begin
                    check("per_cnt_step", per_cnt_o, p);
                    if (p == 0) begin
                        check("first_irq",   irq_o,       1);
                        check("first_rise",  pwm_o,       1);
                        check("ready_after", cfg_ready_o, 1);
                    end
                end
                if (p == 0 && i == 1) irq_ack_i = 1'b1;
                if (p == 0 && i == 2) irq_ack_i = 1'b0;
                if (p == 0 && i == 3) check("irq_ack_clr", irq_o, 0);
                high += int'(pwm_o);
            end
            check("duty5_high", high, 5);
        end

        // Duty boundaries.
        load_and_measure(0,  0,  "duty0_const");
        load_and_measure(16, 16, "duty16_const");
        load_and_measure(31, 16, "duty31_clamp");

        // Duty 3 offered exactly on a wrap while running at 8.
        load_and_measure(8, 8, "duty8_high");
        cfg_valid_i = 1'b1; cfg_duty_i = 5'd3;
        cyc();
        cfg_valid_i = 1'b0;
        check("coinc_ready_low", cfg_ready_o, 0);
        high = int'(pwm_o);
        for (int i = 1; i < FULL; i++) begin
            cyc();
            high += int'(pwm_o);
            if (i == FULL-1) check("coinc_ready_hold", cfg_ready_o, 0);
        end
        check("coinc_keep8", high, 8);
        irq_ack_i = 1'b1;
        cyc();
        irq_ack_i = 1'b0;
        check("irq_set_wins",  irq_o,       1);
        check("coinc_ready_1", cfg_ready_o, 1);
        high = int'(pwm_o);
        for (int i = 1; i < FULL; i++) begin
            cyc();
            high += int'(pwm_o);
        end
        check("coinc_next3", high, 3);
        irq_ack_i = 1'b1;
        cyc();
        irq_ack_i = 1'b0;
        check("irq_lone_ack", irq_o, 0);

        // Upstream counter reset at 9.
        repeat (8) cyc();
        cyc();
        cnt_i = '0;
        per_before = int'(per_cnt_o);
        cyc();
        check("ups_rst_per", per_cnt_o, per_before + 1);
        check("ups_rst_pwm", pwm_o, 1);

        // Asynchronous reset mid-run.
        repeat (3) cyc();
        reset = 1'b1;
        #1;
        check("mid_rst_pwm",   pwm_o,       0);
        check("mid_rst_irq",   irq_o,       0);
        check("mid_rst_per",   per_cnt_o,   0);
        check("mid_rst_ready", cfg_ready_o, 1);
        cyc();
        cyc();
        reset = 1'b0;

        // Randomized traffic against the model.
        last_ready = 1'b1;
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            reset = ($urandom_range(999) == 0);
            cnt_i = ($urandom_range(63) == 0) ? '0 : cnt_i + 1'b1;
            if ($urandom_range(99) == 0) en_i = !en_i;
            if (!cfg_valid_i || last_ready) begin
                cfg_valid_i = ($urandom_range(3) == 0);
                cfg_duty_i  = (WIDTH+1)'($urandom_range(31));
            end
            last_ready = cfg_ready_o;
            irq_ack_i  = ($urandom_range(7) == 0);
        end
        @(negedge clk);
        reset = 1'b0;
        cfg_valid_i = 1'b0;
        irq_ack_i = 1'b0;
        repeat (2) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/cnt_pwm_gen.md
Name: cnt_pwm_gen

Overview:
- Downstream consumer of the free-running WIDTH-bit up-counter output; turns the count into a PWM waveform.
- Duty value arrives over a valid/ready config port, is held pending, and goes live only at a count wrap (glitch-free update).
- Tracks completed periods and raises a sticky update-done interrupt.

Parameters:
- WIDTH, 8, width of cnt_i; must match the upstream counter.
- PCNT_W, 16, width of the period counter per_cnt_o.
- DUTY_RST, 0, duty_act value after reset (0 to 2^WIDTH).

Ports:
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- cnt_i  in  WIDTH  upstream counter value, increments once per clk
- en_i  in  1  PWM enable, level
- cfg_valid_i  in  1  new duty offered
- cfg_ready_o  out  1  config slot free
- cfg_duty_i  in  WIDTH+1  high-time in counts, 0 to 2^WIDTH
- pwm_o  out  1  PWM output, registered
- per_cnt_o  out  PCNT_W  completed periods since enable, saturating
- irq_o  out  1  sticky: pending duty went live
- irq_ack_i  in  1  clears irq_o

Behaviour:
Reset values:
- pwm_o=0, irq_o=0, per_cnt_o=0, cfg_ready_o=1.
- State=IDLE, cnt_q=0, pending=0, duty_act=DUTY_RST.

Wrap detection:
- cnt_q <= cnt_i every cycle.
- wrap = (cnt_i < cnt_q). This covers natural rollover (all-ones to 0) and an upstream reset mid-count. An upstream reset is treated as a period start.

State machine:
- IDLE:
  - pwm_o=0.
  - en_i=1 -> ARMED next cycle. per_cnt_o clears on this transition.
- ARMED:
  - pwm_o=0. Waits for the first wrap.
  - wrap -> RUN. Loads duty_act from pending if pending=1.
  - en_i=0 -> IDLE.
- RUN:
  - pwm_o <= (cnt_i < duty_act). Latency is 1 clk from cnt_i.
  - duty_act = 0 gives constant 0. duty_act = 2^WIDTH gives constant 1.
  - Each wrap increments per_cnt_o, saturating at all-ones.
  - en_i=0 -> IDLE next cycle. pwm_o=0 from that cycle. Pending duty is retained.

Config handshake:
- cfg_ready_o = !pending.
- Transfer when cfg_valid_i and cfg_ready_o are both high: duty_pend <= cfg_duty_i, pending <= 1.
- Values above 2^WIDTH are clamped to 2^WIDTH.
- Accepted in any state, including IDLE.

Duty load:
- On wrap in ARMED or RUN with pending=1: duty_act <= duty_pend, pending <= 0, irq_o <= 1.
- Transfer and wrap in the same cycle with pending=0: the value becomes pending. It loads at the next wrap, not this one.
- While pending=1, cfg_ready_o=0. The source must hold cfg_valid_i and its data stable until ready.

Interrupt:
- irq_ack_i clears irq_o.
- Set and ack in the same cycle: set wins, irq_o stays 1.

Reset mid-operation:
- All state returns to reset values immediately (asynchronous).
- A partially completed config transfer is discarded.

Decomposition:
- Shared package:
  - state enum (IDLE, ARMED, RUN)
  - default WIDTH constant, shared with the upstream counter
  - duty-clamp function
- One natural sub-module: cnt_wrap_det. Holds cnt_q and outputs the wrap pulse; reusable by other count consumers.
- Config pending register and PWM compare stay inline.

Test Plan:
WIDTH=4 for all cases.
- Reset release, en_i=0, cnt_i counting 0..15 -> pwm_o=0, per_cnt_o=0, cfg_ready_o=1, irq_o=0 throughout.
- Duty 5 accepted in IDLE, then en_i=1 -> no PWM until cnt wraps 15->0. Then irq_o=1 and pwm_o high for exactly 5 clks per 16-clk period, rising 1 clk after cnt_i=0. per_cnt_o=1,2,3 at successive wraps.
- Duty boundaries: load 0 -> pwm_o constantly 0. Load 16 -> pwm_o constantly 1. Load 31 -> clamped to 16, constantly 1.
- Duty 3 transfer coincident with a wrap while running at duty 8 -> current period keeps 8. Next period high for 3. cfg_ready_o low from the transfer until that wrap.
- irq_ack_i asserted in the same cycle a new duty goes live -> irq_o remains 1. A following lone ack clears it to 0.
- Upstream counter reset when cnt_i=9 (cnt_i jumps to 0) -> wrap detected, per_cnt_o increments, new period starts. Asserting reset mid-run -> all outputs return to reset values in the same cycle.
